// File: rtl/axis_srl_frame_fifo.sv
// Store-and-forward AXI4-Stream frame FIFO: frames become visible only once their tlast beat is committed.
// Latency: tlast accepted at edge N -> m_axis_tvalid high after edge N; output is a combinational read at rd_ptr.
// Backpressure: never stalls the source (s_axis_tready=1 out of reset); bad or overflowing frames are dropped whole.
//
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   s_axis_*                   input stream (tuser is examined only on the tlast beat)
//   m_axis_*                   output stream, committed frames only
//   frame_count                committed frames not yet fully read
//   good_frame/bad_frame/overflow  one-cycle status pulses per committed / tuser-dropped / overflow-dropped frame
module axis_srl_frame_fifo #(
  parameter int                    DATA_WIDTH           = 8,
  parameter bit                    KEEP_ENABLE          = (DATA_WIDTH > 8),
  parameter int                    KEEP_WIDTH           = ((DATA_WIDTH + 7) / 8),
  parameter int                    USER_WIDTH           = 1,
  parameter logic [USER_WIDTH-1:0] USER_BAD_FRAME_VALUE = 1'b1,
  parameter logic [USER_WIDTH-1:0] USER_BAD_FRAME_MASK  = 1'b1,
  parameter bit                    DROP_BAD_FRAME       = 1'b1,
  parameter int                    DEPTH                = 16
) (
  input  logic                       clk,
  input  logic                       rst_n,

  input  logic [DATA_WIDTH-1:0]      s_axis_tdata,
  input  logic [KEEP_WIDTH-1:0]      s_axis_tkeep,
  input  logic                       s_axis_tvalid,
  output logic                       s_axis_tready,
  input  logic                       s_axis_tlast,
  input  logic [USER_WIDTH-1:0]      s_axis_tuser,

  output logic [DATA_WIDTH-1:0]      m_axis_tdata,
  output logic [KEEP_WIDTH-1:0]      m_axis_tkeep,
  output logic                       m_axis_tvalid,
  input  logic                       m_axis_tready,
  output logic                       m_axis_tlast,

  output logic [$clog2(DEPTH+1)-1:0] frame_count,
  output logic                       good_frame,
  output logic                       bad_frame,
  output logic                       overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  localparam int CW = $clog2(DEPTH + 1);
  // Entry layout: {tlast, [tkeep], tdata}
  localparam int EW = DATA_WIDTH + 1 + (KEEP_ENABLE ? KEEP_WIDTH : 0);

  logic [EW-1:0] mem [DEPTH];

  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] wr_commit_q, wr_commit_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic          drop_frame_q, drop_frame_d;
  logic [CW-1:0] frame_count_q, frame_count_d;
  logic          s_rdy_q;
  logic          good_q, good_d;
  logic          bad_q, bad_d;
  logic          ovf_q, ovf_d;

  logic          wr_en;
  logic [EW-1:0] wr_ent;
  logic [EW-1:0] rd_ent;
  logic          full;
  logic          empty;
  logic          s_hs;
  logic          m_hs;
  logic          user_bad;

  // Full compares against the registered read pointer, so a read this cycle frees space only next cycle.
  assign full     = (wr_ptr_q - rd_ptr_q) == PW'(DEPTH);
  assign empty    = (rd_ptr_q == wr_commit_q);
  assign s_hs     = s_axis_tvalid && s_rdy_q;
  assign m_hs     = m_axis_tvalid && m_axis_tready;
  assign user_bad = DROP_BAD_FRAME &&
                    ((s_axis_tuser & USER_BAD_FRAME_MASK) == (USER_BAD_FRAME_VALUE & USER_BAD_FRAME_MASK));

  generate
    if (KEEP_ENABLE) begin : g_keep
      assign wr_ent       = {s_axis_tlast, s_axis_tkeep, s_axis_tdata};
      assign m_axis_tkeep = rd_ent[DATA_WIDTH +: KEEP_WIDTH];
    end else begin : g_nokeep
      logic unused_keep;
      assign unused_keep  = ^s_axis_tkeep;
      assign wr_ent       = {s_axis_tlast, s_axis_tdata};
      assign m_axis_tkeep = '1;
    end
  endgenerate

  assign rd_ent        = mem[rd_ptr_q[AW-1:0]];
  assign m_axis_tdata  = rd_ent[DATA_WIDTH-1:0];
  assign m_axis_tlast  = rd_ent[EW-1];
  assign m_axis_tvalid = !empty;

  assign s_axis_tready = s_rdy_q;
  assign frame_count   = frame_count_q;
  assign good_frame    = good_q;
  assign bad_frame     = bad_q;
  assign overflow      = ovf_q;

  // Write side: speculative wr_ptr advances per beat; wr_commit moves only on a good tlast.
  always_comb begin
    wr_ptr_d     = wr_ptr_q;
    wr_commit_d  = wr_commit_q;
    drop_frame_d = drop_frame_q;
    wr_en        = 1'b0;
    good_d       = 1'b0;
    bad_d        = 1'b0;
    ovf_d        = 1'b0;
    if (s_hs) begin
      if (drop_frame_q) begin
        if (s_axis_tlast) drop_frame_d = 1'b0;
      end else if (full) begin
        // Rewind to the last commit; keep dropping until tlast unless this beat is the tlast.
        wr_ptr_d     = wr_commit_q;
        ovf_d        = 1'b1;
        drop_frame_d = !s_axis_tlast;
      end else begin
        wr_en    = 1'b1;
        wr_ptr_d = wr_ptr_q + PW'(1);
        if (s_axis_tlast) begin
          if (user_bad) begin
            wr_ptr_d = wr_commit_q;
            bad_d    = 1'b1;
          end else begin
            wr_commit_d = wr_ptr_q + PW'(1);
            good_d      = 1'b1;
          end
        end
      end
    end
  end

  always_comb begin
    rd_ptr_d      = rd_ptr_q + PW'(m_hs);
    frame_count_d = frame_count_q;
    unique case ({good_d, m_hs && m_axis_tlast})
      2'b10:   frame_count_d = frame_count_q + CW'(1);
      2'b01:   frame_count_d = frame_count_q - CW'(1);
      default: frame_count_d = frame_count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q      <= '0;
      wr_commit_q   <= '0;
      rd_ptr_q      <= '0;
      drop_frame_q  <= 1'b0;
      frame_count_q <= '0;
      s_rdy_q       <= 1'b0;
      good_q        <= 1'b0;
      bad_q         <= 1'b0;
      ovf_q         <= 1'b0;
    end else begin
      wr_ptr_q      <= wr_ptr_d;
      wr_commit_q   <= wr_commit_d;
      rd_ptr_q      <= rd_ptr_d;
      drop_frame_q  <= drop_frame_d;
      frame_count_q <= frame_count_d;
      s_rdy_q       <= 1'b1;
      good_q        <= good_d;
      bad_q         <= bad_d;
      ovf_q         <= ovf_d;
    end
  end

  // Storage is not reset; pointers alone define validity.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr_q[AW-1:0]] <= wr_ent;
  end

endmodule

// File: tb/tb_axis_srl_frame_fifo.sv
// Testbench for axis_srl_frame_fifo: scenario tasks drive frames; committed beats go to a scoreboard queue.
// Latency: monitors sample 1-2 ns after the falling edge; stimulus changes on the falling edge.
// Backpressure: m_axis_tready is held low, high or randomised per scenario.
module tb_axis_srl_frame_fifo;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] s_data = '0;
  logic [0:0] s_keep = 1'b1;
  logic       s_vld = 1'b0;
  logic       s_rdy;
  logic       s_last = 1'b0;
  logic [0:0] s_user = 1'b0;
  logic [7:0] m_data;
  logic [0:0] m_keep;
  logic       m_vld;
  logic       m_rdy = 1'b0;
  logic       m_last;
  logic [4:0] frame_count;
  logic       good_frame, bad_frame, overflow;

  int checks = 0;
  int failures = 0;
  int n_good = 0, n_bad = 0, n_ovf = 0;

  typedef struct packed { logic last; logic [7:0] data; } beat_t;
  beat_t sb[$];

  logic       stall_q = 1'b0;
  logic [7:0] stall_data;
  logic       stall_last;

  always #5 clk = ~clk;

  axis_srl_frame_fifo dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .s_axis_tdata  (s_data),
    .s_axis_tkeep  (s_keep),
    .s_axis_tvalid (s_vld),
    .s_axis_tready (s_rdy),
    .s_axis_tlast  (s_last),
    .s_axis_tuser  (s_user),
    .m_axis_tdata  (m_data),
    .m_axis_tkeep  (m_keep),
    .m_axis_tvalid (m_vld),
    .m_axis_tready (m_rdy),
    .m_axis_tlast  (m_last),
    .frame_count   (frame_count),
    .good_frame    (good_frame),
    .bad_frame     (bad_frame),
    .overflow      (overflow)
  );

  // Pulse counters: a stuck-high pulse counts more than once.
  always @(negedge clk) begin
    #1;
    if (rst_n) begin
      n_good += int'(good_frame);
      n_bad  += int'(bad_frame);
      n_ovf  += int'(overflow);
    end
  end

  // Output monitor: pops the scoreboard on each handshake and checks hold-stability while stalled.
  always @(negedge clk) begin
    beat_t exp_b;
    #2;
    if (!rst_n) begin
      stall_q = 1'b0;
    end else begin
      if (stall_q) begin
        checks++;
        if (m_vld !== 1'b1 || m_data !== stall_data || m_last !== stall_last) begin
          failures++;
          $display("FAIL hold_stable got vld=%b data=%h last=%b want vld=1 data=%h last=%b",
                   m_vld, m_data, m_last, stall_data, stall_last);
        end
      end
      if (m_vld === 1'b1 && m_rdy === 1'b1) begin
        checks++;
        if (sb.size() == 0) begin
          failures++;
          $display("FAIL unexpected_beat got data=%h last=%b want no beat", m_data, m_last);
        end else begin
          exp_b = sb.pop_front();
          if (m_data !== exp_b.data || m_last !== exp_b.last || m_keep !== 1'b1) begin
            failures++;
            $display("FAIL out_beat got data=%h last=%b keep=%b want data=%h last=%b keep=1",
                     m_data, m_last, m_keep, exp_b.data, exp_b.last);
          end
        end
      end
      stall_q    = (m_vld === 1'b1) && (m_rdy === 1'b0);
      stall_data = m_data;
      stall_last = m_last;
    end
  end

  task automatic send_beat(input logic [7:0] d, input logic last, input logic u);
    @(negedge clk);
    s_vld  = 1'b1;
    s_data = d;
    s_last = last;
    s_user = u;
  endtask

  task automatic idle();
    @(negedge clk);
    s_vld  = 1'b0;
    s_last = 1'b0;
    s_user = 1'b0;
  endtask

  task automatic push_frame(input int len, input logic [7:0] base);
    for (int i = 0; i < len; i++) sb.push_back({(i == len - 1), 8'(base + i)});
  endtask

  task automatic send_frame(input int len, input logic [7:0] base, input logic u, input bit push);
    if (push) push_frame(len, base);
    for (int i = 0; i < len; i++) send_beat(8'(base + i), (i == len - 1), (i == len - 1) ? u : 1'b0);
  endtask

  task automatic wait_drain(input bit rnd);
    int n = 0;
    while (sb.size() != 0 && n < 500) begin
      @(negedge clk);
      m_rdy = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      n++;
    end
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL drain_timeout got %0d beats left want 0", sb.size());
    end
  endtask

  task automatic check_idle_state(input string name);
    checks++;
    if (frame_count !== 5'd0 || m_vld !== 1'b0) begin
      failures++;
      $display("FAIL %s got frame_count=%0d vld=%b want 0 0", name, frame_count, m_vld);
    end
  endtask

  task automatic test_reset();
    #3;
    checks++;
    if (s_rdy !== 1'b0 || m_vld !== 1'b0 || good_frame !== 1'b0 || bad_frame !== 1'b0 ||
        overflow !== 1'b0 || frame_count !== 5'd0) begin
      failures++;
      $display("FAIL reset_state got rdy=%b vld=%b g=%b b=%b o=%b fc=%0d want all 0",
               s_rdy, m_vld, good_frame, bad_frame, overflow, frame_count);
    end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if (s_rdy !== 1'b1 || m_vld !== 1'b0) begin
      failures++;
      $display("FAIL ready_after_reset got rdy=%b vld=%b want 1 0", s_rdy, m_vld);
    end
  endtask

  task automatic test_good_frame();
    int g0 = n_good;
    m_rdy = 1'b1;
    push_frame(4, 8'h11);
    for (int i = 0; i < 4; i++) begin
      send_beat(8'(8'h11 + i), (i == 3), 1'b0);
      checks++;
      if (m_vld !== 1'b0) begin
        failures++;
        $display("FAIL early_valid beat=%0d got vld=%b want 0", i, m_vld);
      end
    end
    idle();
    checks++;
    if (m_vld !== 1'b1 || frame_count !== 5'd1) begin
      failures++;
      $display("FAIL commit_visible got vld=%b fc=%0d want 1 1", m_vld, frame_count);
    end
    repeat (4) @(negedge clk);
    check_idle_state("good_drained");
    #2;
    checks++;
    if (n_good - g0 != 1) begin
      failures++;
      $display("FAIL good_pulse got %0d want 1", n_good - g0);
    end
  endtask

  task automatic test_bad_frame();
    int g0 = n_good;
    int b0 = n_bad;
    m_rdy = 1'b1;
    for (int i = 0; i < 3; i++) send_beat(8'(8'h30 + i), (i == 2), (i == 2));
    idle();
    repeat (3) begin
      checks++;
      if (m_vld !== 1'b0) begin
        failures++;
        $display("FAIL bad_not_visible got vld=%b want 0", m_vld);
      end
      @(negedge clk);
    end
    checks++;
    if (n_bad - b0 != 1 || n_good - g0 != 0) begin
      failures++;
      $display("FAIL bad_pulse got bad=%0d good=%0d want 1 0", n_bad - b0, n_good - g0);
    end
    send_frame(2, 8'hA0, 1'b0, 1'b1);
    idle();
    wait_drain(1'b0);
    check_idle_state("after_bad");
  endtask

  task automatic test_overflow();
    int o0 = n_ovf;
    int g0 = n_good;
    m_rdy = 1'b0;
    for (int i = 0; i < 20; i++) begin
      send_beat(8'(8'h40 + i), (i == 19), 1'b0);
      #2;
      if (i == 16) begin
        checks++;
        if (n_ovf - o0 != 0) begin
          failures++;
          $display("FAIL ovf_early got %0d want 0", n_ovf - o0);
        end
      end
      if (i == 17) begin
        checks++;
        if (n_ovf - o0 != 1) begin
          failures++;
          $display("FAIL ovf_on_beat17 got %0d want 1", n_ovf - o0);
        end
      end
    end
    idle();
    repeat (2) @(negedge clk);
    check_idle_state("ovf_dropped");
    checks++;
    if (n_ovf - o0 != 1 || n_good - g0 != 0) begin
      failures++;
      $display("FAIL ovf_pulse_count got ovf=%0d good=%0d want 1 0", n_ovf - o0, n_good - g0);
    end
    send_frame(5, 8'hB0, 1'b0, 1'b1);
    idle();
    checks++;
    if (m_vld !== 1'b1 || frame_count !== 5'd1) begin
      failures++;
      $display("FAIL after_ovf_commit got vld=%b fc=%0d want 1 1", m_vld, frame_count);
    end
    wait_drain(1'b0);
    check_idle_state("after_ovf_drained");
  endtask

  task automatic test_back_to_back();
    int g0 = n_good;
    m_rdy = 1'b0;
    for (int f = 0; f < 3; f++) send_frame(4, 8'(8'h50 + 4 * f), 1'b0, 1'b1);
    idle();
    #2;
    checks++;
    if (frame_count !== 5'd3 || n_good - g0 != 3) begin
      failures++;
      $display("FAIL b2b_count got fc=%0d good=%0d want 3 3", frame_count, n_good - g0);
    end
    wait_drain(1'b1);
    check_idle_state("b2b_drained");
  endtask

  task automatic test_continuous();
    int g0 = n_good;
    m_rdy = 1'b1;
    for (int k = 0; k < 10; k++) begin
      push_frame(1, 8'(8'h60 + k));
      send_beat(8'(8'h60 + k), 1'b1, 1'b0);
      if (k >= 1) begin
        checks++;
        if (frame_count !== 5'd1 || m_vld !== 1'b1) begin
          failures++;
          $display("FAIL cont_steady k=%0d got fc=%0d vld=%b want 1 1", k, frame_count, m_vld);
        end
      end
    end
    idle();
    wait_drain(1'b0);
    check_idle_state("cont_drained");
    #2;
    checks++;
    if (n_good - g0 != 10) begin
      failures++;
      $display("FAIL cont_good got %0d want 10", n_good - g0);
    end
  endtask

  task automatic test_mid_reset();
    m_rdy = 1'b0;
    send_frame(2, 8'h70, 1'b0, 1'b1);
    send_frame(2, 8'h72, 1'b0, 1'b1);
    send_beat(8'h74, 1'b0, 1'b0);
    send_beat(8'h75, 1'b0, 1'b0);
    checks++;
    if (frame_count !== 5'd2) begin
      failures++;
      $display("FAIL pre_reset_count got %0d want 2", frame_count);
    end
    #1;
    rst_n = 1'b0;
    #1;
    checks++;
    if (m_vld !== 1'b0 || frame_count !== 5'd0 || s_rdy !== 1'b0) begin
      failures++;
      $display("FAIL async_reset got vld=%b fc=%0d rdy=%b want 0 0 0", m_vld, frame_count, s_rdy);
    end
    sb.delete();
    s_vld  = 1'b0;
    s_last = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if (s_rdy !== 1'b1 || m_vld !== 1'b0) begin
      failures++;
      $display("FAIL post_reset got rdy=%b vld=%b want 1 0", s_rdy, m_vld);
    end
    send_frame(3, 8'h80, 1'b0, 1'b1);
    idle();
    wait_drain(1'b1);
    check_idle_state("post_reset_drained");
  endtask

  initial begin
    test_reset();
    test_good_frame();
    test_bad_frame();
    test_overflow();
    test_back_to_back();
    test_continuous();
    test_mid_reset();
    repeat (5) @(negedge clk);
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL final_scoreboard got %0d beats left want 0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
